// File: rtl/quantized_act_serializer_if.sv
// Activation-in / serial-frame-out bundle for quantized_act_serializer.
// master: the environment (quantizer side and bit-serial sink).
// slave:  the serializer itself.
interface quantized_act_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]         act_in;
    logic                          act_valid;
    logic                          sink_ready;
    logic                          serial_out;
    logic                          serial_valid;
    logic                          frame_first;
    logic                          frame_last;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output act_in, act_valid, sink_ready,
        input  serial_out, serial_valid, frame_first, frame_last, fifo_count, overflow
    );

    modport slave (
        input  act_in, act_valid, sink_ready,
        output serial_out, serial_valid, frame_first, frame_last, fifo_count, overflow
    );
endinterface

// File: rtl/quantized_act_serializer.sv
// Buffers 8-bit quantized activations in a small FIFO and re-emits each as a
// FRAME_LEN-bit, zero-extended bit-serial frame. Frames begin only when the
// sink is ready at a frame boundary and then run to completion; back-to-back
// frames have no gap cycle.
//
// Build option: define ACT_SERIALIZER_MSB_FIRST_EN to emit leading zeros
// followed by the activation MSB first. Default is LSB first with trailing
// zero-extension.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame on the wire; waiting for a queued value and sink_ready
// SHIFT | emitting frame bit bit_cnt (0..FRAME_LEN-1)
module quantized_act_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    quantized_act_serializer_if.slave       bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(FRAME_LEN);
`ifdef ACT_SERIALIZER_MSB_FIRST_EN
    // Full frame width so the leading zeros fall out of the top naturally.
    localparam int SH_W  = FRAME_LEN;
`else
    localparam int SH_W  = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state, state_nx;
    logic [SH_W-1:0]      sh, sh_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic                 bit_nx;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic                 full, push, pop;

    logic                 serial_out_q, serial_valid_q, frame_first_q, frame_last_q;

    // Pop uses the registered count, so a value written this cycle cannot
    // be read out before the next one. A pop at full frees the slot the push
    // needs, so that push is accepted.
    assign full = (count == FULL_COUNT);
    assign push = bus.act_valid && (!full || pop);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state, FIFO pop and shift-register update.
    always_comb begin
        state_nx   = state;
        sh_nx      = sh;
        bit_cnt_nx = bit_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && bus.sink_ready) begin
                    pop        = 1'b1;
                    state_nx   = SHIFT;
                    sh_nx      = SH_W'(mem[rd_ptr]);
                    bit_cnt_nx = '0;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (count != '0 && bus.sink_ready) begin
                        pop        = 1'b1;
                        sh_nx      = SH_W'(mem[rd_ptr]);
                        bit_cnt_nx = '0;
                    end else begin
                        state_nx   = IDLE;
                    end
                end else begin
`ifdef ACT_SERIALIZER_MSB_FIRST_EN
                    sh_nx      = sh << 1;
`else
                    sh_nx      = sh >> 1;
`endif
                    bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ACT_SERIALIZER_MSB_FIRST_EN
    assign bit_nx = sh_nx[SH_W-1];
`else
    assign bit_nx = sh_nx[0];
`endif

    // Shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            sh      <= sh_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    // Outputs are flopped from the next-cycle state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_first_q  <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            serial_valid_q <= (state_nx == SHIFT);
            serial_out_q   <= (state_nx == SHIFT) && bit_nx;
            frame_first_q  <= (state_nx == SHIFT) && (bit_cnt_nx == '0);
            frame_last_q   <= (state_nx == SHIFT) && (bit_cnt_nx == LAST_BIT);
        end
    end

    // FIFO storage; contents are discarded on reset via the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.act_in;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.act_valid && full && !pop) overflow <= 1'b1;
        end
    end

    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.frame_first  = frame_first_q;
    assign bus.frame_last   = frame_last_q;
    assign bus.fifo_count   = count;
    assign bus.overflow     = overflow;
endmodule

// File: tb/tb_quantized_act_serializer.sv
// Bench for quantized_act_serializer: directed scenarios plus random traffic,
// each cycle compared against a queue-based frame model.
module tb_quantized_act_serializer;
    localparam int DW = 8;
    localparam int FL = 32;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;
`ifdef ACT_SERIALIZER_MSB_FIRST_EN
    localparam bit FIRST_BIT_A5 = 1'b0;
`else
    localparam bit FIRST_BIT_A5 = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    quantized_act_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

    quantized_act_serializer #(
        .DATA_WIDTH(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: queued values, position in current frame (-1 = no frame), value.
    int q[$];
    int pos = -1;
    int cur = 0;
    bit ovf = 1'b0;

    function automatic void model_edge(input bit rst, input bit av, input int ai, input bit sr);
        bit boundary;
        if (rst) begin
            q.delete();
            pos = -1;
            ovf = 1'b0;
            return;
        end
        boundary = (pos < 0) || (pos == FL - 1);
        if (boundary && q.size() > 0 && sr) begin
            cur = q.pop_front();
            pos = 0;
        end else if (boundary) begin
            pos = -1;
        end else begin
            pos = pos + 1;
        end
        if (av) begin
            if (q.size() < FD) q.push_back(ai & 'hFF);
            else               ovf = 1'b1;
        end
    endfunction

    function automatic bit exp_bit();
        if (pos < 0) return 1'b0;
`ifdef ACT_SERIALIZER_MSB_FIRST_EN
        if (pos < FL - DW) return 1'b0;
        return 1'((cur >> (DW - 1 - (pos - (FL - DW)))) & 1);
`else
        if (pos >= DW) return 1'b0;
        return 1'((cur >> pos) & 1);
`endif
    endfunction

    function automatic logic [CW+4:0] exp_vec();
        return {pos >= 0, exp_bit(), pos == 0, pos == FL - 1, CW'(q.size()), ovf};
    endfunction

    function automatic logic [CW+4:0] obs_vec();
        return {bus.serial_valid, bus.serial_out, bus.frame_first, bus.frame_last,
                bus.fifo_count, bus.overflow};
    endfunction

    task automatic step(input bit rst, input bit av, input int ai, input bit sr);
        reset          = rst;
        bus.act_valid  = av;
        bus.act_in     = ai[DW-1:0];
        bus.sink_ready = sr;
        @(posedge clk);
        model_edge(rst, av, ai, sr);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 'h3C, 1'b1);
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_values cyc=%0d got=%b exp=0", cyc, obs_vec());
        end
        step(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int valid_cycles = 0;
        step(1'b0, 1'b1, 'hA5, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            if (bus.serial_valid) valid_cycles++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (bus.frame_first !== 1'b1 || bus.serial_out !== FIRST_BIT_A5) begin
                    errors++;
                    $display("FAIL single_latency first=%b bit=%b exp first=1 bit=%b",
                             bus.frame_first, bus.serial_out, FIRST_BIT_A5);
                end
            end
        end
        checks++;
        if (valid_cycles != FL) begin
            errors++;
            $display("FAIL single_length got=%0d exp=%0d", valid_cycles, FL);
        end
    endtask

    task automatic test_back_to_back();
        int valid_cycles = 0;
        int firsts = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, (i == 0) || (i == 32), (i == 0) ? 'hFF : 'h01, 1'b1);
            if (bus.serial_valid) valid_cycles++;
            if (bus.frame_first) firsts++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (valid_cycles != 2 * FL || firsts != 2) begin
            errors++;
            $display("FAIL back_to_back_len valid=%0d firsts=%0d exp valid=%0d firsts=2",
                     valid_cycles, firsts, 2 * FL);
        end
    endtask

    task automatic test_backpressure();
        int firsts = 0;
        step(1'b1, 1'b0, 0, 1'b0);
        for (int v = 1; v <= 4; v++) step(1'b0, 1'b1, v, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (bus.fifo_count !== CW'(4) || bus.serial_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold count=%0d valid=%b exp count=4 valid=0",
                     bus.fifo_count, bus.serial_valid);
        end
        for (int i = 0; i < 4 * FL + 4; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            if (bus.frame_first) firsts++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (firsts != 4) begin
            errors++;
            $display("FAIL backpressure_frames got=%0d exp=4", firsts);
        end
    endtask

    task automatic test_overflow();
        int firsts = 0;
        step(1'b1, 1'b0, 0, 1'b0);
        for (int v = 1; v <= 4; v++) step(1'b0, 1'b1, v, 1'b0);
        step(1'b0, 1'b1, 'h55, 1'b1);
        checks++;
        if (bus.fifo_count !== CW'(4) || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pop_at_full count=%0d ovf=%b exp count=4 ovf=0",
                     bus.fifo_count, bus.overflow);
        end
        for (int i = 0; i < 5 * FL + 4; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_drain cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        for (int v = 'h11; v <= 'h15; v++) step(1'b0, 1'b1, v, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (bus.fifo_count !== CW'(4) || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set count=%0d ovf=%b exp count=4 ovf=1",
                     bus.fifo_count, bus.overflow);
        end
        for (int i = 0; i < 4 * FL + 4; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            if (bus.frame_first) firsts++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_frames cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (firsts != 4 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky frames=%0d ovf=%b exp frames=4 ovf=1", firsts, bus.overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        int valid_cycles = 0;
        step(1'b1, 1'b0, 0, 1'b0);
        for (int v = 'h21; v <= 'h23; v++) step(1'b0, 1'b1, v, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        while (pos != 10 && guard < 60) begin
            step(1'b0, 1'b0, 0, 1'b0);
            guard++;
        end
        checks++;
        if (pos != 10 || bus.fifo_count !== CW'(2)) begin
            errors++;
            $display("FAIL reset_mid_setup pos=%0d count=%0d exp pos=10 count=2", pos, bus.fifo_count);
        end
        step(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%b exp=0", obs_vec());
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            if (bus.serial_valid) valid_cycles++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (valid_cycles != 0) begin
            errors++;
            $display("FAIL reset_mid_no_frames got=%0d exp=0", valid_cycles);
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            step(1'b0, $urandom_range(0, 19) == 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.act_valid  = 1'b0;
        bus.act_in     = '0;
        bus.sink_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/quantized_act_serializer.md
# quantized_act_serializer

Downstream stage of the activation/quantization unit. It accepts one 8-bit quantized activation per frame and buffers it in a small FIFO. It then re-emits each value as a fixed-length, LSB-first, zero-extended bit-serial frame for the next layer's bit-serial MAC array. Frames start only when the sink is ready; once started, a frame runs to completion without stalls.

## Interface
- DATA_WIDTH, 8: width of the quantized activation.
- FRAME_LEN, 32: bits per emitted serial frame; must be ≥ DATA_WIDTH.
- FIFO_DEPTH, 4: activation FIFO entries; power of two, ≥ 2.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- act_in  in  DATA_WIDTH  quantized activation from the quantizer's output_array.
- act_valid  in  1  one-cycle strobe: act_in is new this cycle.
- sink_ready  in  1  downstream can accept a new frame; sampled only at frame boundaries.
- serial_out  out  1  current serial bit.
- serial_valid  out  1  serial_out is a frame bit.
- frame_first  out  1  high on bit 0 of a frame.
- frame_last  out  1  high on bit FRAME_LEN-1 of a frame.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- overflow  out  1  sticky: an activation was dropped because the FIFO was full.

## Operation
- FIFO behaviour:
  - Circular buffer with read/write pointers and count.
  - Push occurs when act_valid is high.
  - Pop is issued by the FSM.
- FSM states: IDLE and SHIFT.
- IDLE:
  - If fifo_count > 0 and sink_ready: pop the head into shift register sh[DATA_WIDTH-1:0], set bit_cnt=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - serial_valid=1; serial_out=sh[0].
  - Each cycle, sh shifts right with zero fill and bit_cnt increments.
  - Bits DATA_WIDTH..FRAME_LEN-1 are therefore 0 (unsigned zero-extension; activations are non-negative after ReLU).
- At bit_cnt==FRAME_LEN-1:
  - If fifo_count > 0 and sink_ready: pop the next entry, bit_cnt=0, stay in SHIFT (back-to-back frames, no gap cycle).
  - Otherwise go to IDLE.
- sink_ready is ignored mid-frame.
- Push when full with no pop in the same cycle: the value is dropped, FIFO is unchanged, overflow is set.
- Push when full with a pop in the same cycle: the push is accepted and count is unchanged.
- No bypass: a value pushed in cycle T cannot be popped before cycle T+1.
- overflow clears only on reset.

## Timing
- All outputs are registered.
- Reset values: serial_out=0, serial_valid=0, frame_first=0, frame_last=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame: the frame is aborted, FIFO contents are discarded, and all outputs return to reset values on the next edge.
- Latency: act_valid in cycle T into an empty FIFO, with IDLE and sink_ready high in T+1, gives frame_first/bit 0 in cycle T+2.
- A frame occupies exactly FRAME_LEN consecutive serial_valid cycles.
- Sustained throughput: one frame per FRAME_LEN cycles. This matches the quantizer's one-output-per-32-cycle rate at the defaults, so the FIFO only absorbs sink back-pressure.
- fifo_count reflects pushes/pops of the previous edge.

## Configuration
- Macro ACT_SERIALIZER_MSB_FIRST_EN.
- Defined:
  - Each frame first emits FRAME_LEN-DATA_WIDTH leading zeros.
  - It then emits the DATA_WIDTH activation bits MSB first.
  - The shift register shifts left.
  - frame_first/frame_last positions are unchanged.
- Undefined (default): LSB-first with trailing zero-extension, as in Operation.

## Test plan
- Single value: reset, sink_ready=1, act_in=8'hA5 pulsed once. Expect frame_first 2 cycles later, serial_out bits 1,0,1,0,0,1,0,1 then 24 zeros, frame_last on the 32nd bit, then IDLE with serial_valid=0.
- Back-to-back: push 8'hFF at cycle 0 and 8'h01 at cycle 32. Expect 64 contiguous serial_valid cycles, second frame_first immediately after the first frame_last, second frame = 1 followed by 31 zeros.
- Back-pressure: sink_ready=0, push 4 values (8'h01..8'h04). Expect fifo_count=4 and serial_valid=0. Raise sink_ready: four frames in order 1,2,3,4 with no gaps, fifo_count decrementing at each frame start.
- Overflow: with sink_ready=0, push 5 values. Expect fifo_count=4, overflow=1 and sticky, fifth value never emitted. Same test with a push coinciding with a pop at full: value accepted, overflow unchanged.
- Reset mid-frame: assert reset at bit 10 of a frame with 2 entries queued. Expect all outputs 0 next cycle, fifo_count=0, no further frames after reset release.
- With ACT_SERIALIZER_MSB_FIRST_EN: act_in=8'h81. Expect 24 zeros, then 1,0,0,0,0,0,0,1.
